// File: rtl/ppe_sync.sv
// Partial-processing element: loads a 1-D filter from weight packets, then
// slides it across each accepted spike row, emitting one psum packet per position.
module ppe_sync #(
  parameter int PKT_W           = 30,
  parameter int ADDR_W          = 4,
  parameter int MY_ADDR         = 5,
  parameter int OUT_ADDR        = 9,
  parameter int W_BITS          = 8,
  parameter int WEIGHTS_PER_PKT = 3,
  parameter int FILTER_W        = 5,
  parameter int IFMAP_W         = 25,
  parameter int PSUM_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_data,
  output logic             out_last,
  output logic             weights_ready,
  output logic             err_pulse
);

  localparam int OUT_N  = IFMAP_W - FILTER_W + 1;
  localparam int IDX_W  = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int PTR_W  = $clog2(FILTER_W + WEIGHTS_PER_PKT + 1);
  localparam int OP_BIT = PKT_W - ADDR_W - 1;
  localparam int WB_W   = W_BITS * WEIGHTS_PER_PKT;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(OUT_N - 1);
  localparam logic [ADDR_W-1:0] MY_A     = ADDR_W'(MY_ADDR);
  localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_ADDR);
  localparam logic [PTR_W-1:0]  FULL_PTR = PTR_W'(FILTER_W);

  logic [0:0]               state;
  logic [IFMAP_W-1:0]       row_reg;
  logic [IDX_W-1:0]         idx_reg;
  logic [PTR_W-1:0]         ptr_reg;
  logic [FILTER_W-1:0][W_BITS-1:0]        taps;
  logic [WEIGHTS_PER_PKT-1:0][W_BITS-1:0] wbytes;

  logic in_fire, out_fire, addr_ok, opcode;
  logic w_acc, s_acc, drop, advance, finish;
  logic [PTR_W-1:0] ptr_sum;

  assign in_ready = (state == S_IDLE);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign addr_ok  = (in_data[PKT_W-1 -: ADDR_W] == MY_A);
  assign opcode   = in_data[OP_BIT];
  assign w_acc    = in_fire && addr_ok && !opcode;
  // A spike row is only usable once every tap holds a weight.
  assign s_acc    = in_fire && addr_ok && opcode && weights_ready;
  assign drop     = in_fire && !(w_acc || s_acc);
  assign advance  = out_fire && (idx_reg != LAST_IDX);
  assign finish   = out_fire && (idx_reg == LAST_IDX);
  assign ptr_sum  = ptr_reg + PTR_W'(WEIGHTS_PER_PKT);

  // Weight bytes, most significant first.
  for (genvar gj = 0; gj < WEIGHTS_PER_PKT; gj++) begin : g_wbyte
    assign wbytes[gj] = in_data[WB_W-1-gj*W_BITS -: W_BITS];
  end

  // Each tap picks up the byte whose offset from the pointer lands on it.
  for (genvar gi = 0; gi < FILTER_W; gi++) begin : g_tap
    logic              we;
    logic [W_BITS-1:0] wval;
    logic [W_BITS-1:0] tap_reg;

    always_comb begin
      we   = 1'b0;
      wval = '0;
      for (int j = 0; j < WEIGHTS_PER_PKT; j++) begin
        if (w_acc && (int'(ptr_reg) + j == gi)) begin
          we   = 1'b1;
          wval = wbytes[j];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tap_reg <= '0;
      end else if (we) begin
        tap_reg <= wval;
      end
    end

    assign taps[gi] = tap_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      weights_ready <= 1'b0;
    end else if (w_acc) begin
      if (ptr_sum >= FULL_PTR) begin
        ptr_reg       <= '0;
        weights_ready <= 1'b1;
      end else begin
        ptr_reg       <= ptr_sum;
        weights_ready <= 1'b0;
      end
    end
  end

  // Psum for the next packet: index 0 of the incoming row on acceptance,
  // otherwise the following index of the latched row.
  logic [IFMAP_W-1:0] row_sel;
  logic [IFMAP_W-1:0] window;
  logic [IDX_W-1:0]   idx_sel;
  logic [PSUM_W-1:0]  psum_next;
  logic [PKT_W-1:0]   pkt_next;

  always_comb begin
    row_sel   = s_acc ? in_data[IFMAP_W-1:0] : row_reg;
    idx_sel   = s_acc ? '0 : idx_reg + 1'b1;
    window    = row_sel >> idx_sel;
    psum_next = '0;
    for (int k = 0; k < FILTER_W; k++) begin
      if (window[k]) begin
        psum_next = psum_next + PSUM_W'(taps[k]);
      end
    end
    pkt_next                       = '0;
    pkt_next[PKT_W-1 -: ADDR_W]    = OUT_A;
    pkt_next[PSUM_W +: IDX_W]      = idx_sel;
    pkt_next[PSUM_W-1:0]           = psum_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      row_reg   <= '0;
      idx_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (s_acc) begin
      state     <= S_EMIT;
      row_reg   <= in_data[IFMAP_W-1:0];
      idx_reg   <= '0;
      out_valid <= 1'b1;
      out_data  <= pkt_next;
      out_last  <= (LAST_IDX == '0);
    end else if (advance) begin
      idx_reg   <= idx_sel;
      out_data  <= pkt_next;
      out_last  <= (idx_sel == LAST_IDX);
    end else if (finish) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= drop;
    end
  end

endmodule

// File: tb/tb_ppe_sync.sv
// Directed bench for ppe_sync: table of packet transactions with expected flags,
// plus hand-written emission, stall and reset-mid-row sequences.
module tb_ppe_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [29:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [29:0] out_data;
  logic        out_last;
  logic        weights_ready;
  logic        err_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int mt [5];

  always #5 clk = ~clk;

  ppe_sync dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .weights_ready(weights_ready), .err_pulse(err_pulse)
  );

  typedef struct {
    string       name;
    logic [29:0] pkt;
    logic        exp_err;
    logic        exp_wr;
  } vec_t;

  vec_t tbl [9];

  localparam logic [24:0] ROW_ALT  = 25'h0AAAAAA;
  localparam logic [24:0] ROW_ONES = 25'h1FFFFFF;

  function automatic logic [29:0] wpkt(input logic [3:0] a, input logic [7:0] b0,
                                       input logic [7:0] b1, input logic [7:0] b2);
    return {a, 1'b0, 1'b0, b0, b1, b2};
  endfunction

  function automatic logic [29:0] spkt(input logic [3:0] a, input logic [24:0] row);
    return {a, 1'b1, row};
  endfunction

  function automatic logic [29:0] exp_out(input logic [24:0] row, input int o);
    int s;
    s = 0;
    for (int k = 0; k < 5; k++) if (row[o+k]) s += mt[k];
    return {4'd9, 1'b0, 4'b0, 5'(o), 16'(s)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [29:0] p);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = p;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v);
    send(v.pkt);
    chk({v.name, "_err"}, 32'(err_pulse), 32'(v.exp_err));
    chk({v.name, "_wr"}, 32'(weights_ready), 32'(v.exp_wr));
    chk({v.name, "_noout"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({v.name, "_errclr"}, 32'(err_pulse), 32'd0);
    $display("vec %s pkt=%h err=%0b wr=%0b", v.name, v.pkt, v.exp_err, v.exp_wr);
  endtask

  task automatic run_row(input string name, input logic [24:0] row, input int stall_idx);
    logic [29:0] e;
    send(spkt(4'd5, row));
    chk({name, "_latency"}, 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      e = exp_out(row, i);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_data"}, 32'(out_data), 32'(e));
      chk({name, "_last"}, 32'(out_last), 32'(i == 20));
      chk({name, "_inrdy"}, 32'(in_ready), 32'd0);
      if (i == stall_idx) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          chk({name, "_hold_data"}, 32'(out_data), 32'(e));
          chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
          chk({name, "_hold_inrdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk({name, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_done_inrdy"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    $display("row %s emitted 21 packets (stall at %0d)", name, stall_idx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{"spike_noweights", spkt(4'd5, ROW_ALT), 1'b1, 1'b0};
    tbl[1] = '{"w_012",           wpkt(4'd5, 8'd0, 8'd1, 8'd2), 1'b0, 1'b0};
    tbl[2] = '{"w_345",           wpkt(4'd5, 8'd3, 8'd4, 8'd5), 1'b0, 1'b1};
    tbl[3] = '{"spike_addr7",     spkt(4'd7, ROW_ALT), 1'b1, 1'b1};
    tbl[4] = '{"w_ff_a",          wpkt(4'd5, 8'hFF, 8'hFF, 8'hFF), 1'b0, 1'b0};
    tbl[5] = '{"w_ff_b",          wpkt(4'd5, 8'hFF, 8'hFF, 8'h11), 1'b0, 1'b1};
    tbl[6] = '{"w_partial",       wpkt(4'd5, 8'd10, 8'd20, 8'd30), 1'b0, 1'b0};
    tbl[7] = '{"spike_partial",   spkt(4'd5, ROW_ALT), 1'b1, 1'b0};
    tbl[8] = '{"w_finish",        wpkt(4'd5, 8'd40, 8'd50, 8'd60), 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wr", 32'(weights_ready), 32'd0);

    for (int i = 0; i < 4; i++) apply_vec(tbl[i]);
    mt = '{0, 1, 2, 3, 4};
    run_row("alt", ROW_ALT, -1);
    run_row("alt_stall", ROW_ALT, 3);

    for (int i = 4; i < 6; i++) apply_vec(tbl[i]);
    mt = '{255, 255, 255, 255, 255};
    run_row("ones", ROW_ONES, -1);
    chk("ones_psum_1275", 32'(exp_out(ROW_ONES, 7) & 30'hFFFF), 32'd1275);

    for (int i = 6; i < 9; i++) apply_vec(tbl[i]);
    mt = '{10, 20, 30, 40, 50};

    send(spkt(4'd5, ROW_ALT));
    out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("mid_idx10", 32'(out_data), 32'(exp_out(ROW_ALT, 10)));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_wr", 32'(weights_ready), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_inrdy", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    $display("reset during index 10 applied");
    out_ready = 1'b0;
    v = '{"spike_after_rst", spkt(4'd5, ROW_ALT), 1'b1, 1'b0};
    apply_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
